// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the decode stage and its register file.
package decode_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [4:0]  X0      = 5'd0;
  localparam logic [1:0]  OPC_LOW = 2'b11;

  typedef enum logic [6:0] {
    OpLoad    = 7'h03,
    OpMiscMem = 7'h0f,
    OpImm     = 7'h13,
    OpAuipc   = 7'h17,
    OpImm32   = 7'h1b,
    OpStore   = 7'h23,
    OpReg     = 7'h33,
    OpLui     = 7'h37,
    OpReg32   = 7'h3b,
    OpBranch  = 7'h63,
    OpJalr    = 7'h67,
    OpJal     = 7'h6f,
    OpSystem  = 7'h73
  } opcode_t;

  typedef enum logic [2:0] {
    ImmI = 3'd0,
    ImmS = 3'd1,
    ImmB = 3'd2,
    ImmU = 3'd3,
    ImmJ = 3'd4
  } imm_src_t;

endpackage

// File: rtl/reg_file.sv
// Two-read, one-write register file with x0 tied to zero and write-to-read bypass.
module reg_file
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            wr_en;

  // The E-variant has no x16..x31; such writes are dropped rather than aliased.
  assign wr_en = we_i && (waddr_i != X0) && ((NREGS == 32) || !waddr_i[4]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = '0;
    if (raddr1_i != X0) begin
      rdata1_o = (we_i && waddr_i == raddr1_i) ? wdata_i : mem_q[raddr1_i[AW-1:0]];
    end
  end

  always_comb begin
    rdata2_o = '0;
    if (raddr2_i != X0) begin
      rdata2_o = (we_i && waddr_i == raddr2_i) ? wdata_i : mem_q[raddr2_i[AW-1:0]];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV decode stage: two-entry skid buffer, field split, bypassed register read,
// immediate generation, pc+4 and illegal-encoding detection.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr_f,
  input  logic [XLEN-1:0]    pc_f,
  input  logic               valid_f,
  output logic               ready_f,
  input  logic               flush_d,
  input  imm_src_t           imm_src_d,
  input  logic [4:0]         rd_w,
  input  logic [XLEN-1:0]    result_w,
  input  logic               reg_write_w,
  output opcode_t            op,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [4:0]         rs1_d,
  output logic [4:0]         rs2_d,
  output logic [4:0]         rd_d,
  output logic [XLEN-1:0]    rd1_d,
  output logic [XLEN-1:0]    rd2_d,
  output logic [XLEN-1:0]    pc_d,
  output logic [XLEN-1:0]    pc_plus_4_d,
  output logic [XLEN-1:0]    imm_ext_d,
  output logic               illegal_d,
  output logic               valid_d,
  input  logic               ready_e
);

  logic [INSTR_W-1:0] main_instr_q, skid_instr_q;
  logic [XLEN-1:0]    main_pc_q, skid_pc_q;
  logic               main_valid_q, skid_valid_q;
  logic               accept, drain;
  logic [31:0]        imm32;
  logic               bad_reg;

  // ready_f comes straight from a flop, so ready_e never reaches it combinationally.
  assign ready_f = !skid_valid_q;
  assign valid_d = main_valid_q;
  assign accept  = valid_f && ready_f;
  assign drain   = main_valid_q && ready_e;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_instr_q <= '0;
      main_pc_q    <= '0;
      main_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else if (flush_d) begin
      main_instr_q <= '0;
      main_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_valid_q <= 1'b0;
    end else if (drain && skid_valid_q) begin
      main_instr_q <= skid_instr_q;
      main_pc_q    <= skid_pc_q;
      skid_valid_q <= 1'b0;
    end else if (accept && (!main_valid_q || drain)) begin
      main_instr_q <= instr_f;
      main_pc_q    <= pc_f;
      main_valid_q <= 1'b1;
    end else if (accept) begin
      skid_instr_q <= instr_f;
      skid_pc_q    <= pc_f;
      skid_valid_q <= 1'b1;
    end else if (drain) begin
      main_instr_q <= '0;
      main_valid_q <= 1'b0;
    end
  end

  assign op     = opcode_t'(main_instr_q[6:0]);
  assign rd_d   = main_instr_q[11:7];
  assign funct3 = main_instr_q[14:12];
  assign rs1_d  = main_instr_q[19:15];
  assign rs2_d  = main_instr_q[24:20];
  assign funct7 = main_instr_q[31:25];

  assign pc_d        = main_pc_q;
  assign pc_plus_4_d = main_pc_q + XLEN'(4);

  always_comb begin
    imm32 = '0;
    unique case (imm_src_d)
      ImmI: imm32 = {{20{main_instr_q[31]}}, main_instr_q[31:20]};
      ImmS: imm32 = {{20{main_instr_q[31]}}, main_instr_q[31:25], main_instr_q[11:7]};
      ImmB: imm32 = {{19{main_instr_q[31]}}, main_instr_q[31], main_instr_q[7],
                     main_instr_q[30:25], main_instr_q[11:8], 1'b0};
      ImmU: imm32 = {main_instr_q[31:12], 12'b0};
      ImmJ: imm32 = {{11{main_instr_q[31]}}, main_instr_q[31], main_instr_q[19:12],
                     main_instr_q[20], main_instr_q[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_ext_d       = {XLEN{imm32[31]}};
    imm_ext_d[31:0] = imm32;
  end

  assign bad_reg   = (NREGS == 16) && (rs1_d[4] || rs2_d[4] || rd_d[4]);
  assign illegal_d = main_valid_q && ((main_instr_q[1:0] != OPC_LOW) || bad_reg);

  reg_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_reg_file (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .raddr1_i (rs1_d),
    .raddr2_i (rs2_d),
    .rdata1_o (rd1_d),
    .rdata2_o (rd2_d),
    .we_i     (reg_write_w),
    .waddr_i  (rd_w),
    .wdata_i  (result_w)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: RV32I instance against a queue/array model, plus an
// RV64E instance for the wide-immediate and E-variant encoding rules.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // RV32I instance
  logic [31:0] instr_f, pc_f, result_w;
  logic        valid_f, flush_d, ready_e, reg_write_w;
  logic [4:0]  rd_w;
  imm_src_t    imm_src_d;
  logic        ready_f, valid_d, illegal_d;
  opcode_t     op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [31:0] rd1_d, rd2_d, pc_d, pc_plus_4_d, imm_ext_d;

  // RV64E instance
  logic [31:0] instr_f_b;
  logic [63:0] pc_f_b, result_w_b;
  logic        valid_f_b, reg_write_w_b;
  logic [4:0]  rd_w_b;
  logic        ready_f_b, valid_d_b, illegal_d_b;
  opcode_t     op_b;
  logic [2:0]  funct3_b;
  logic [6:0]  funct7_b;
  logic [4:0]  rs1_d_b, rs2_d_b, rd_d_b;
  logic [63:0] rd1_d_b, rd2_d_b, pc_d_b, pc_plus_4_d_b, imm_ext_d_b;

  decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .reset_n(reset_n), .instr_f(instr_f), .pc_f(pc_f), .valid_f(valid_f),
    .ready_f(ready_f), .flush_d(flush_d), .imm_src_d(imm_src_d), .rd_w(rd_w),
    .result_w(result_w), .reg_write_w(reg_write_w), .op(op), .funct3(funct3),
    .funct7(funct7), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .rd1_d(rd1_d),
    .rd2_d(rd2_d), .pc_d(pc_d), .pc_plus_4_d(pc_plus_4_d), .imm_ext_d(imm_ext_d),
    .illegal_d(illegal_d), .valid_d(valid_d), .ready_e(ready_e)
  );

  decode_stage #(.XLEN(64), .NREGS(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .instr_f(instr_f_b), .pc_f(pc_f_b), .valid_f(valid_f_b),
    .ready_f(ready_f_b), .flush_d(1'b0), .imm_src_d(ImmI), .rd_w(rd_w_b),
    .result_w(result_w_b), .reg_write_w(reg_write_w_b), .op(op_b), .funct3(funct3_b),
    .funct7(funct7_b), .rs1_d(rs1_d_b), .rs2_d(rs2_d_b), .rd_d(rd_d_b), .rd1_d(rd1_d_b),
    .rd2_d(rd2_d_b), .pc_d(pc_d_b), .pc_plus_4_d(pc_plus_4_d_b), .imm_ext_d(imm_ext_d_b),
    .illegal_d(illegal_d_b), .valid_d(valid_d_b), .ready_e(1'b1)
  );

  int checks = 0;
  int errors = 0;

  // Model: the stage is a FIFO of at most two instructions; registers are a plain array.
  logic [31:0] mq_instr[$];
  logic [31:0] mq_pc[$];
  logic [31:0] mregs[32];

  function automatic logic [31:0] head_instr();
    if (mq_instr.size() > 0) return mq_instr[0];
    return 32'h0;
  endfunction

  function automatic logic [31:0] imm_ref(input logic [31:0] i, input imm_src_t s);
    case (s)
      ImmI: return (i[31] ? 32'hFFFFF800 : 32'h0) | 32'(i[30:20]);
      ImmS: return (i[31] ? 32'hFFFFF800 : 32'h0) | (32'(i[30:25]) << 5) | 32'(i[11:7]);
      ImmB: return (i[31] ? 32'hFFFFF000 : 32'h0) | (32'(i[7]) << 11) |
                   (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      ImmU: return i & 32'hFFFFF000;
      ImmJ: return (i[31] ? 32'hFFF00000 : 32'h0) | (32'(i[19:12]) << 12) |
                   (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rd_ref(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (reg_write_w && rd_w == rs) return result_w;
    return mregs[rs];
  endfunction

  function automatic logic [31:0] rand_instr();
    return $urandom() | 32'h3;
  endfunction

  function automatic void model_reset();
    mq_instr.delete();
    mq_pc.delete();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic tick();
    bit acc, dr;
    @(posedge clk);
    acc = valid_f && (mq_instr.size() < 2);
    dr  = (mq_instr.size() > 0) && ready_e;
    if (flush_d) begin
      mq_instr.delete();
      mq_pc.delete();
    end else begin
      if (dr) begin
        void'(mq_instr.pop_front());
        void'(mq_pc.pop_front());
      end
      if (acc) begin
        mq_instr.push_back(instr_f);
        mq_pc.push_back(pc_f);
      end
    end
    if (reg_write_w && rd_w != 5'd0) mregs[rd_w] = result_w;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    valid_f = 1'b1; instr_f = 32'h00500093; pc_f = 32'h40; ready_e = 1'b1;
    flush_d = 1'b0; reg_write_w = 1'b0; rd_w = 5'd0; result_w = 32'h0; imm_src_d = ImmI;
    valid_f_b = 1'b1; instr_f_b = 32'h00500093; pc_f_b = 64'h40;
    reg_write_w_b = 1'b0; rd_w_b = 5'd0; result_w_b = 64'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({valid_d, ready_f, illegal_d} !== 3'b010) begin
      errors++; $display("FAIL reset_flags got %b exp 010", {valid_d, ready_f, illegal_d});
    end
    checks++;
    if ({funct7, rs2_d, rs1_d, funct3, rd_d, op} !== 32'h0) begin
      errors++; $display("FAIL reset_fields got %h exp 0", {funct7, rs2_d, rs1_d, funct3, rd_d, op});
    end
    checks++;
    if ({rd1_d, rd2_d, imm_ext_d, pc_d} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp 0", rd1_d, rd2_d, imm_ext_d, pc_d);
    end
    checks++;
    if (pc_plus_4_d !== 32'h4) begin
      errors++; $display("FAIL reset_pc4 got %h exp 4", pc_plus_4_d);
    end
    checks++;
    if (pc_plus_4_d_b !== 64'h4 || imm_ext_d_b !== 64'h0 || valid_d_b !== 1'b0) begin
      errors++; $display("FAIL reset_b got pc4 %h imm %h v %b exp 4 0 0",
                         pc_plus_4_d_b, imm_ext_d_b, valid_d_b);
    end
    // Release with the instruction still offered: it is taken on the first edge.
    reset_n = 1'b1; ready_e = 1'b0; valid_f_b = 1'b0;
    tick();
    @(negedge clk); valid_f = 1'b0; #1;
    checks++;
    if (valid_d !== 1'b1 || rd_d !== 5'd1 || imm_ext_d !== 32'd5) begin
      errors++; $display("FAIL first_accept got v %b rd %0d imm %h exp 1 1 5", valid_d, rd_d, imm_ext_d);
    end
    ready_e = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    logic [31:0] sent[4];
    ready_e = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) begin
        sent[k] = rand_instr();
        valid_f = 1'b1; instr_f = sent[k]; pc_f = 32'h100 + 32'(4 * k);
      end else begin
        valid_f = 1'b0;
      end
      #1;
      checks++;
      if (ready_f !== 1'b1) begin
        errors++; $display("FAIL stream_ready cyc %0d got %b exp 1", k, ready_f);
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if (valid_d !== 1'b1 || pc_d !== 32'h100 + 32'(4 * (k - 1)) ||
            pc_plus_4_d !== 32'h104 + 32'(4 * (k - 1)) ||
            {funct7, rs2_d, rs1_d, funct3, rd_d, op} !== sent[k-1]) begin
          errors++; $display("FAIL stream_head cyc %0d got v %b pc %h pc4 %h ins %h exp pc %h ins %h",
                             k, valid_d, pc_d, pc_plus_4_d, {funct7, rs2_d, rs1_d, funct3, rd_d, op},
                             32'h100 + 32'(4 * (k - 1)), sent[k-1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pool[8];
    logic [31:0] got[$];
    int nxt = 0;
    bit saw_stall = 1'b0;
    int bad = 0;
    for (int i = 0; i < 8; i++) pool[i] = rand_instr();
    for (int c = 0; c < 40 && !(nxt == 8 && got.size() == 8); c++) begin
      @(negedge clk);
      valid_f = (nxt < 8);
      instr_f = pool[nxt % 8];
      pc_f    = 32'h300 + 32'(4 * nxt);
      ready_e = !(c >= 2 && c < 5);
      #1;
      checks++;
      if (ready_f !== (mq_instr.size() < 2) || valid_d !== (mq_instr.size() > 0)) begin
        errors++; $display("FAIL bp_handshake cyc %0d got rf %b vd %b exp occupancy %0d",
                           c, ready_f, valid_d, mq_instr.size());
      end
      if (!ready_f) saw_stall = 1'b1;
      if (valid_d && ready_e) got.push_back({funct7, rs2_d, rs1_d, funct3, rd_d, op});
      if (valid_f && mq_instr.size() < 2) nxt++;
      tick();
    end
    valid_f = 1'b0;
    checks++;
    if (!saw_stall) begin
      errors++; $display("FAIL bp_stall got ready_f never 0 exp a stall");
    end
    for (int i = 0; i < 8; i++) if (i >= got.size() || got[i] !== pool[i]) bad++;
    checks++;
    if (got.size() != 8 || bad != 0) begin
      errors++; $display("FAIL bp_order got %0d entries %0d wrong exp 8 in order", got.size(), bad);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk); valid_f = 1'b0; ready_e = 1'b1;
    repeat (3) tick();
    @(negedge clk); valid_f = 1'b1; instr_f = 32'h00528333; pc_f = 32'h200; ready_e = 1'b0;
    tick();
    @(negedge clk); valid_f = 1'b0; reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'hDEADBEEF; #1;
    checks++;
    if (rd1_d !== 32'hDEADBEEF || rd2_d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_same got %h %h exp deadbeef", rd1_d, rd2_d);
    end
    tick();
    @(negedge clk); reg_write_w = 1'b0; #1;
    checks++;
    if (rd1_d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_stored got %h exp deadbeef", rd1_d);
    end
    ready_e = 1'b1;
    tick();
    @(negedge clk); valid_f = 1'b1; instr_f = 32'h00500333; ready_e = 1'b0;
    tick();
    @(negedge clk); valid_f = 1'b0; reg_write_w = 1'b1; rd_w = 5'd0; result_w = 32'h12345678; #1;
    checks++;
    if (rd1_d !== 32'h0 || rd2_d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_x0 got %h %h exp 0 deadbeef", rd1_d, rd2_d);
    end
    tick();
    @(negedge clk); reg_write_w = 1'b0; #1;
    checks++;
    if (rd1_d !== 32'h0) begin
      errors++; $display("FAIL x0_stored got %h exp 0", rd1_d);
    end
    ready_e = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    @(negedge clk); valid_f = 1'b1; instr_f = rand_instr(); ready_e = 1'b0;
    tick();
    @(negedge clk); instr_f = rand_instr();
    tick();
    @(negedge clk); #1;
    checks++;
    if (ready_f !== 1'b0 || valid_d !== 1'b1) begin
      errors++; $display("FAIL flush_full got rf %b vd %b exp 0 1", ready_f, valid_d);
    end
    flush_d = 1'b1; valid_f = 1'b1; instr_f = 32'h00700093;
    tick();
    @(negedge clk); flush_d = 1'b0; valid_f = 1'b0; #1;
    checks++;
    if (valid_d !== 1'b0 || ready_f !== 1'b1 || {funct7, rs2_d, rs1_d, funct3, rd_d, op} !== 32'h0) begin
      errors++; $display("FAIL flush_clear got vd %b rf %b ins %h exp 0 1 0",
                         valid_d, ready_f, {funct7, rs2_d, rs1_d, funct3, rd_d, op});
    end
    tick();
    @(negedge clk); #1;
    checks++;
    if (valid_d !== 1'b0) begin
      errors++; $display("FAIL flush_drop got vd %b exp 0", valid_d);
    end
    ready_e = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] hi;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      valid_f     = ($urandom() % 4) != 0;
      instr_f     = $urandom();
      if (($urandom() % 8) != 0) instr_f = instr_f | 32'h3;
      pc_f        = (($urandom() % 16) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
      ready_e     = ($urandom() % 3) != 0;
      flush_d     = ($urandom() % 20) == 0;
      reg_write_w = $urandom() % 2;
      rd_w        = 5'($urandom());
      result_w    = $urandom();
      imm_src_d   = imm_src_t'($urandom_range(0, 4));
      #1;
      hi = head_instr();
      checks++;
      if (valid_d !== (mq_instr.size() > 0) || ready_f !== (mq_instr.size() < 2)) begin
        errors++; $display("FAIL rnd_hs cyc %0d got vd %b rf %b exp occupancy %0d",
                           c, valid_d, ready_f, mq_instr.size());
      end
      checks++;
      if ({funct7, rs2_d, rs1_d, funct3, rd_d, op} !== hi ||
          illegal_d !== ((mq_instr.size() > 0) && hi[1:0] != 2'b11)) begin
        errors++; $display("FAIL rnd_fields cyc %0d got %h ill %b exp %h",
                           c, {funct7, rs2_d, rs1_d, funct3, rd_d, op}, illegal_d, hi);
      end
      checks++;
      if (imm_ext_d !== imm_ref(hi, imm_src_d)) begin
        errors++; $display("FAIL rnd_imm cyc %0d got %h exp %h", c, imm_ext_d, imm_ref(hi, imm_src_d));
      end
      checks++;
      if (rd1_d !== rd_ref(hi[19:15]) || rd2_d !== rd_ref(hi[24:20])) begin
        errors++; $display("FAIL rnd_regs cyc %0d got %h %h exp %h %h", c, rd1_d, rd2_d,
                           rd_ref(hi[19:15]), rd_ref(hi[24:20]));
      end
      if (mq_instr.size() > 0) begin
        checks++;
        if (pc_d !== mq_pc[0] || pc_plus_4_d !== mq_pc[0] + 32'd4) begin
          errors++; $display("FAIL rnd_pc cyc %0d got %h %h exp %h", c, pc_d, pc_plus_4_d, mq_pc[0]);
        end
      end
      tick();
    end
    flush_d = 1'b0; reg_write_w = 1'b0; imm_src_d = ImmI;
  endtask

  task automatic test_async_reset();
    @(negedge clk); valid_f = 1'b1; instr_f = rand_instr(); ready_e = 1'b0;
    reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'hCAFE0001;
    tick();
    @(negedge clk); instr_f = rand_instr(); reg_write_w = 1'b0;
    tick();
    @(negedge clk); valid_f = 1'b0; #2;
    reset_n = 1'b0; #1;
    checks++;
    if (valid_d !== 1'b0 || ready_f !== 1'b1 || {funct7, rs2_d, rs1_d, funct3, rd_d, op} !== 32'h0) begin
      errors++; $display("FAIL async_reset got vd %b rf %b ins %h exp 0 1 0",
                         valid_d, ready_f, {funct7, rs2_d, rs1_d, funct3, rd_d, op});
    end
    model_reset();
    @(negedge clk); reset_n = 1'b1; valid_f = 1'b1; instr_f = 32'h00528333;
    tick();
    @(negedge clk); valid_f = 1'b0; #1;
    checks++;
    if (rd1_d !== 32'h0 || valid_d !== 1'b1) begin
      errors++; $display("FAIL regs_cleared got rd1 %h vd %b exp 0 1", rd1_d, valid_d);
    end
    ready_e = 1'b1;
    tick();
  endtask

  task automatic test_bad_encodings();
    logic [31:0] ins[5];
    logic [63:0] exp_imm[5];
    logic [63:0] pcs[5];
    logic        exp_ill;
    ins[0] = 32'h01F00093; exp_imm[0] = 64'h1F;
    ins[1] = 32'hFFF00093; exp_imm[1] = 64'hFFFFFFFFFFFFFFFF;
    ins[2] = 32'h00100893; exp_imm[2] = 64'h1;
    ins[3] = 32'h00100091; exp_imm[3] = 64'h1;
    ins[4] = 32'h00100113; exp_imm[4] = 64'h1;
    pcs[0] = 64'h1000; pcs[1] = 64'hFFFFFFFFFFFFFFFC; pcs[2] = 64'hFFFFFFFC;
    pcs[3] = 64'h8; pcs[4] = 64'h2000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); valid_f_b = 1'b1; instr_f_b = ins[k]; pc_f_b = pcs[k];
      @(posedge clk);
      @(negedge clk); valid_f_b = 1'b0; #1;
      exp_ill = (ins[k][1:0] != 2'b11) || ins[k][11] || ins[k][19] || ins[k][24];
      checks++;
      if (imm_ext_d_b !== exp_imm[k] || illegal_d_b !== exp_ill || valid_d_b !== 1'b1 ||
          pc_plus_4_d_b !== pcs[k] + 64'd4) begin
        errors++; $display("FAIL rv64e_%0d got imm %h ill %b vd %b pc4 %h exp %h %b 1 %h",
                           k, imm_ext_d_b, illegal_d_b, valid_d_b, pc_plus_4_d_b,
                           exp_imm[k], exp_ill, pcs[k] + 64'd4);
      end
      @(posedge clk);
    end
    // A write to x17 on the E-variant must not alias onto x1.
    @(negedge clk); reg_write_w_b = 1'b1; rd_w_b = 5'd17; result_w_b = 64'h55;
    valid_f_b = 1'b1; instr_f_b = 32'h00008093; pc_f_b = 64'h0;
    @(posedge clk);
    @(negedge clk); reg_write_w_b = 1'b0; valid_f_b = 1'b0; #1;
    checks++;
    if (rd1_d_b !== 64'h0) begin
      errors++; $display("FAIL rv64e_x17_alias got %h exp 0", rd1_d_b);
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bypass();
    test_flush();
    test_random();
    test_async_reset();
    test_bad_encodings();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
